// File: rtl/uart_perip.sv
// Memory-mapped 8N1 UART: CTRL/STATUS/BAUD/TX/RX registers with TX and RX bit engines.
// Define UART_FRAME_ERR_EN to latch stop-bit framing errors in STATUS bit2.
module uart_perip #(
  parameter int unsigned BAUD_DIV_RST = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_pin,
  input  logic        rx_pin
);

  localparam logic [7:0] AddrCtrl   = 8'h00;
  localparam logic [7:0] AddrStatus = 8'h04;
  localparam logic [7:0] AddrBaud   = 8'h08;
  localparam logic [7:0] AddrTx     = 8'h0C;
  localparam logic [7:0] AddrRx     = 8'h10;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic        r_tx_en, r_rx_en, r_rx_over;
  logic [31:0] r_baud;
  logic [7:0]  r_rx_data;
  logic        w_status_ferr;

  logic [7:0]  w_addr;
  logic        w_wr_ctrl, w_wr_status, w_wr_baud, w_wr_tx;
  logic [31:0] w_baud_eff;
  logic        w_unused;

  assign w_addr      = addr_i[7:0];
  assign w_wr_ctrl   = we_i && (w_addr == AddrCtrl);
  assign w_wr_status = we_i && (w_addr == AddrStatus);
  assign w_wr_baud   = we_i && (w_addr == AddrBaud);
  assign w_wr_tx     = we_i && (w_addr == AddrTx);
  // Divisors below 4 would leave no room for the half-bit RX centring.
  assign w_baud_eff  = (r_baud < 32'd4) ? 32'd4 : r_baud;

  // ---------------- TX engine ----------------
  tx_state_e   r_tx_state, w_tx_state_d;
  logic [31:0] r_tx_cnt, w_tx_cnt_d, r_tx_div, w_tx_div_d;
  logic [7:0]  r_tx_shift, w_tx_shift_d;
  logic [2:0]  r_tx_bit, w_tx_bit_d;
  logic        w_tx_busy;

  assign w_tx_busy = (r_tx_state != TxIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TxIdle;
      r_tx_cnt   <= '0;
      r_tx_div   <= '0;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_cnt   <= w_tx_cnt_d;
      r_tx_div   <= w_tx_div_d;
      r_tx_shift <= w_tx_shift_d;
      r_tx_bit   <= w_tx_bit_d;
    end
  end

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_cnt_d   = r_tx_cnt;
    w_tx_div_d   = r_tx_div;
    w_tx_shift_d = r_tx_shift;
    w_tx_bit_d   = r_tx_bit;
    unique case (r_tx_state)
      TxIdle: begin
        if (w_wr_tx && r_tx_en) begin
          w_tx_state_d = TxStart;
          w_tx_div_d   = w_baud_eff;
          w_tx_cnt_d   = w_baud_eff - 32'd1;
          w_tx_shift_d = data_i[7:0];
          w_tx_bit_d   = '0;
        end
      end
      TxStart: begin
        if (r_tx_cnt == '0) begin
          w_tx_state_d = TxData;
          w_tx_cnt_d   = r_tx_div - 32'd1;
        end else begin
          w_tx_cnt_d = r_tx_cnt - 32'd1;
        end
      end
      TxData: begin
        if (r_tx_cnt == '0) begin
          w_tx_cnt_d   = r_tx_div - 32'd1;
          w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_d   = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_state_d = TxStop;
        end else begin
          w_tx_cnt_d = r_tx_cnt - 32'd1;
        end
      end
      TxStop: begin
        if (r_tx_cnt == '0) w_tx_state_d = TxIdle;
        else                w_tx_cnt_d   = r_tx_cnt - 32'd1;
      end
      default: w_tx_state_d = TxIdle;
    endcase
  end

  // Decoded from state so reset drives the line idle without waiting for a clock.
  always_comb begin
    tx_pin = 1'b1;
    unique case (r_tx_state)
      TxStart: tx_pin = 1'b0;
      TxData:  tx_pin = r_tx_shift[0];
      default: tx_pin = 1'b1;
    endcase
  end

  // ---------------- RX engine ----------------
  rx_state_e   r_rx_state, w_rx_state_d;
  logic [31:0] r_rx_cnt, w_rx_cnt_d, r_rx_div, w_rx_div_d;
  logic [7:0]  r_rx_shift, w_rx_shift_d;
  logic [2:0]  r_rx_bit, w_rx_bit_d;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic        w_rx_fall, w_rx_done, w_rx_bad;

  assign w_rx_fall = r_rx_prev && !r_rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RxIdle;
      r_rx_cnt   <= '0;
      r_rx_div   <= '0;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_s1    <= rx_pin;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_d;
      r_rx_cnt   <= w_rx_cnt_d;
      r_rx_div   <= w_rx_div_d;
      r_rx_shift <= w_rx_shift_d;
      r_rx_bit   <= w_rx_bit_d;
    end
  end

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_cnt_d   = r_rx_cnt;
    w_rx_div_d   = r_rx_div;
    w_rx_shift_d = r_rx_shift;
    w_rx_bit_d   = r_rx_bit;
    w_rx_done    = 1'b0;
    w_rx_bad     = 1'b0;
    if (!r_rx_en) begin
      w_rx_state_d = RxIdle;
    end else begin
      unique case (r_rx_state)
        RxIdle: begin
          if (w_rx_fall) begin
            w_rx_state_d = RxStart;
            w_rx_div_d   = w_baud_eff;
            w_rx_cnt_d   = (w_baud_eff >> 1) - 32'd1;
          end
        end
        RxStart: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_s2) begin
              w_rx_state_d = RxIdle;
            end else begin
              w_rx_state_d = RxData;
              w_rx_cnt_d   = r_rx_div - 32'd1;
              w_rx_bit_d   = '0;
            end
          end else begin
            w_rx_cnt_d = r_rx_cnt - 32'd1;
          end
        end
        RxData: begin
          if (r_rx_cnt == '0) begin
            w_rx_shift_d = {r_rx_s2, r_rx_shift[7:1]};
            w_rx_bit_d   = r_rx_bit + 3'd1;
            w_rx_cnt_d   = r_rx_div - 32'd1;
            if (r_rx_bit == 3'd7) w_rx_state_d = RxStop;
          end else begin
            w_rx_cnt_d = r_rx_cnt - 32'd1;
          end
        end
        RxStop: begin
          if (r_rx_cnt == '0) begin
            w_rx_state_d = RxIdle;
            w_rx_done    = r_rx_s2;
            w_rx_bad     = !r_rx_s2;
          end else begin
            w_rx_cnt_d = r_rx_cnt - 32'd1;
          end
        end
        default: w_rx_state_d = RxIdle;
      endcase
    end
  end

  // ---------------- Register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_en   <= 1'b0;
      r_rx_en   <= 1'b0;
      r_baud    <= 32'(BAUD_DIV_RST);
      r_rx_data <= '0;
      r_rx_over <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_tx_en <= data_i[0];
        r_rx_en <= data_i[1];
      end
      if (w_wr_baud) r_baud <= data_i;
      if (w_rx_done) r_rx_data <= r_rx_shift;
      // A completing byte outranks a simultaneous software clear.
      if (w_rx_done)        r_rx_over <= 1'b1;
      else if (w_wr_status) r_rx_over <= data_i[1];
    end
  end

`ifdef UART_FRAME_ERR_EN
  logic r_frame_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_frame_err <= 1'b0;
    else if (w_rx_bad)    r_frame_err <= 1'b1;
    else if (w_wr_status) r_frame_err <= data_i[2];
  end
  assign w_status_ferr = r_frame_err;
`else
  assign w_status_ferr = 1'b0;
`endif

  assign w_unused = ^{addr_i[31:8], w_rx_bad};

  always_comb begin
    data_o = '0;
    unique case (w_addr)
      AddrCtrl:   data_o = {30'd0, r_rx_en, r_tx_en};
      AddrStatus: data_o = {29'd0, w_status_ferr, r_rx_over, w_tx_busy};
      AddrBaud:   data_o = r_baud;
      AddrRx:     data_o = {24'd0, r_rx_data};
      default:    data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_perip.sv
// Directed/randomised bench for uart_perip with a frame-level reference model.
module tb_uart_perip;

  logic        clk, rst_n, we_i, tx_pin, rx_pin;
  logic [31:0] addr_i, data_i, data_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_rx_data;
  logic       exp_rx_over;
  logic       exp_ferr;

  uart_perip #(.BAUD_DIV_RST(434)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .tx_pin (tx_pin),
    .rx_pin (rx_pin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] Base = 32'h3000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr_i = Base | {24'd0, a};
    #1;
    chk(tag, data_o, exp);
    addr_i = Base | 32'h4;
  endtask

  // Called at a negedge; returns at the next negedge with the write applied.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    we_i   = 1'b1;
    addr_i = Base | {24'd0, a};
    data_i = d;
    @(negedge clk);
    we_i   = 1'b0;
    addr_i = Base | 32'h4;
  endtask

  function automatic int eff_of(input int b);
    return (b < 4) ? 4 : b;
  endfunction

  // Level of an 8N1 frame at cycle i, bits of eff cycles each.
  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int i,
                                     input int eff);
    int k;
    k = i / eff;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9) return stop;
    return 1'b1;
  endfunction

  // Sends one TX byte and checks every cycle; an ignored TX write lands at cycle 20 and a
  // BAUD write of new_baud at cycle 30, neither of which may disturb this frame.
  task automatic tx_frame(input logic [7:0] b, input int eff, input logic [31:0] new_baud);
    int len;
    len = 10 * eff;
    bus_write(8'h0C, {24'd0, b});
    for (int i = 0; i <= len; i++) begin
      we_i   = 1'b0;
      addr_i = Base | 32'h4;
      #1;
      chk($sformatf("tx_pin[%0d] byte %h", i, b), {31'd0, tx_pin},
          {31'd0, (i < len) ? frame_bit(b, 1'b1, i, eff) : 1'b1});
      chk($sformatf("tx_busy[%0d]", i), {31'd0, data_o[0]}, {31'd0, (i < len)});
      if (i < len) begin
        if (i == 20) begin
          we_i = 1'b1; addr_i = Base | 32'hC; data_i = $urandom;
        end else if (i == 30) begin
          we_i = 1'b1; addr_i = Base | 32'h8; data_i = new_baud;
        end
        @(negedge clk);
      end
    end
  endtask

  // Drives an RX frame starting at the current negedge; optionally writes STATUS=0 so it
  // lands on the posedge numbered clr_at+1 after the falling edge.
  task automatic send_rx(input logic [7:0] b, input logic stop, input int eff, input int clr_at);
    for (int c = 0; c < 10 * eff + 8; c++) begin
      rx_pin = frame_bit(b, stop, c, eff);
      addr_i = Base | 32'h4;
      if (c == clr_at) begin
        we_i = 1'b1; data_i = 32'd0;
      end else begin
        we_i = 1'b0;
      end
      @(negedge clk);
    end
    we_i   = 1'b0;
    rx_pin = 1'b1;
  endtask

  function automatic logic [31:0] exp_status();
    return {29'd0, exp_ferr, exp_rx_over, 1'b0};
  endfunction

  initial begin
    int          eff, bw, nb;
    logic [7:0]  b;

    rst_n = 1'b0; we_i = 1'b0; rx_pin = 1'b1;
    addr_i = Base; data_i = 32'd0;
    exp_rx_data = 8'h00; exp_rx_over = 1'b0; exp_ferr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values and register access.
    rd_chk("rst_ctrl", 8'h00, 32'd0);
    rd_chk("rst_status", 8'h04, 32'd0);
    rd_chk("rst_baud", 8'h08, 32'd434);
    rd_chk("rst_rx", 8'h10, 32'd0);
    chk("rst_tx_pin", {31'd0, tx_pin}, 32'd1);
    bus_write(8'h00, 32'hFFFF_FFFF);
    rd_chk("ctrl_rw", 8'h00, 32'd3);
    bus_write(8'h14, 32'hDEAD_BEEF);
    rd_chk("unmapped_rd", 8'h14, 32'd0);
    rd_chk("tx_reads0", 8'h0C, 32'd0);
    rd_chk("ctrl_after_unmapped", 8'h00, 32'd3);
    bus_write(8'h00, 32'hFFFF_FFFC);
    rd_chk("ctrl_clear", 8'h00, 32'd0);

    // TX disabled: write ignored.
    bus_write(8'h08, 32'd8);
    bus_write(8'h0C, 32'h55);
    #1;
    chk("tx_disabled_pin", {31'd0, tx_pin}, 32'd1);
    rd_chk("tx_disabled_busy", 8'h04, 32'd0);

    // TX frames, back to back, with mid-frame BAUD changes applying to the next frame.
    bus_write(8'h00, 32'd1);
    bw = $urandom_range(10, 4);
    tx_frame(8'hA5, 8, bw);
    tx_frame(8'($urandom), eff_of(bw), 32'd2);
    tx_frame(8'($urandom), 4, 32'd8);
    rd_chk("baud_after_tx", 8'h08, 32'd8);

    // RX basic.
    bus_write(8'h00, 32'd2);
    send_rx(8'h3C, 1'b1, 8, -1);
    exp_rx_data = 8'h3C; exp_rx_over = 1'b1;
    rd_chk("rx_status", 8'h04, exp_status());
    rd_chk("rx_data", 8'h10, 32'h3C);
    bus_write(8'h04, 32'd0);
    exp_rx_over = 1'b0;
    rd_chk("rx_clear", 8'h04, exp_status());

    // Random bytes and divisors; overwrite keeps rx_over set.
    for (int k = 0; k < 3; k++) begin
      bw = $urandom_range(10, 1);
      bus_write(8'h08, bw);
      b = 8'($urandom);
      send_rx(b, 1'b1, eff_of(bw), -1);
      exp_rx_data = b; exp_rx_over = 1'b1;
      rd_chk($sformatf("rx_rand%0d_status", k), 8'h04, exp_status());
      rd_chk($sformatf("rx_rand%0d_data", k), 8'h10, {24'd0, exp_rx_data});
    end

    // Glitch: short low pulse is not a start bit.
    bus_write(8'h08, 32'd8);
    bus_write(8'h04, 32'd0);
    exp_rx_over = 1'b0;
    rx_pin = 1'b0;
    repeat (2) @(negedge clk);
    rx_pin = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("glitch_status", 8'h04, exp_status());
    rd_chk("glitch_data", 8'h10, {24'd0, exp_rx_data});

    // Clear/set collision: the clear lands on the completing edge (2+1+BAUD/2+9*BAUD).
    eff = 8;
    b = 8'($urandom);
    send_rx(b, 1'b1, eff, 2 + eff / 2 + 9 * eff);
    exp_rx_data = b; exp_rx_over = 1'b1;
    rd_chk("collide_status", 8'h04, exp_status());
    rd_chk("collide_data", 8'h10, {24'd0, exp_rx_data});

    // Framing error: byte discarded.
    bus_write(8'h04, 32'd0);
    exp_rx_over = 1'b0;
    send_rx(8'($urandom), 1'b0, 8, -1);
`ifdef UART_FRAME_ERR_EN
    exp_ferr = 1'b1;
`endif
    rd_chk("ferr_status", 8'h04, exp_status());
    rd_chk("ferr_data", 8'h10, {24'd0, exp_rx_data});
    bus_write(8'h04, 32'd0);
    exp_ferr = 1'b0;
    rd_chk("ferr_clear", 8'h04, exp_status());

    // RX disabled: frame ignored.
    bus_write(8'h00, 32'd0);
    send_rx(8'h81, 1'b1, 8, -1);
    rd_chk("rx_disabled_status", 8'h04, exp_status());
    rd_chk("rx_disabled_data", 8'h10, {24'd0, exp_rx_data});

    // Asynchronous reset in the middle of a TX start bit.
    bus_write(8'h00, 32'd3);
    bus_write(8'h0C, 32'hF0);
    repeat (2) @(negedge clk);
    #1;
    chk("pre_reset_pin", {31'd0, tx_pin}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pin", {31'd0, tx_pin}, 32'd1);
    rd_chk("reset_ctrl", 8'h00, 32'd0);
    rd_chk("reset_status", 8'h04, 32'd0);
    rd_chk("reset_baud", 8'h08, 32'd434);
    rd_chk("reset_rx", 8'h10, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_pin", {31'd0, tx_pin}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_perip.md
# uart_perip

Memory-mapped UART peripheral in the 0x3000_0000 slot of the SoC bus. It is the downstream stage of the UART debug loader and of CPU firmware: they program control and baud, poll status, write TX bytes and read RX bytes. It serialises 8N1 frames on `tx_pin` and deserialises 8N1 frames from `rx_pin`.

## Interface
- `BAUD_DIV_RST`, default 434: reset value of the BAUD register, in clk cycles per bit (115200 baud at 50 MHz).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `we_i`  in  1  write strobe for the current bus cycle.
- `addr_i`  in  32  byte address; only `addr_i[7:0]` is decoded; the bus fabric selects the slot.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data, combinational from `addr_i`. Reset value 0x0000_0000, except at offset 0x08 where it is `BAUD_DIV_RST`.
- `tx_pin`  out  1  serial output; reset value 1 (idle).
- `rx_pin`  in  1  serial input, asynchronous to `clk`.

## Operation
Register map (offset: function):
- **0x00 CTRL** (R/W)
  - bit0 tx_en, bit1 rx_en; reset 0.
  - Other bits read 0.
- **0x04 STATUS**
  - bit0 tx_busy, read-only.
  - bit1 rx_over: set when a byte is received; a write loads `data_i[1]`, so writing 0 clears it.
- **0x08 BAUD** (R/W)
  - Bits [31:0]; cycles per bit.
  - Written values < 4 act as 4.
- **0x0C TX** (W)
  - A write of `data_i[7:0]` starts a frame only if tx_en=1 and tx_busy=0; otherwise it is ignored.
  - Reads 0.
- **0x10 RX** (R): bits [7:0] hold the last received byte; upper bits read 0.
- Unmapped offsets read 0; writes to them are ignored.

TX FSM (TX_IDLE, TX_START, TX_DATA, TX_STOP):
- A TX write accepted in cycle N loads the shift register and latches BAUD into the TX divisor. In N+1: state TX_START, `tx_pin`=0, tx_busy=1.
- Each state lasts exactly BAUD cycles, counted by a 32-bit down-counter.
- TX_DATA shifts out 8 bits, LSB first; a 3-bit bit counter wraps 7→0 to leave the state.
- TX_STOP drives 1, then returns to TX_IDLE, where tx_busy=0.
- Clearing tx_en mid-frame does not abort the frame.

RX path:
- `rx_pin` passes through a 2-flop synchronizer, reset to 1.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP. BAUD is latched at frame start.
- RX_IDLE: a falling edge of the synchronized line with rx_en=1 enters RX_START.
- RX_START: wait BAUD>>1 cycles, then re-sample.
  - Sample 1: glitch, return to RX_IDLE.
  - Sample 0: go to RX_DATA.
- RX_DATA: sample every BAUD cycles, 8 bits, LSB first.
- RX_STOP: sample once after BAUD cycles.
  - Sample 1: RX data register ← byte, and rx_over ← 1 on the next edge.
  - Sample 0: framing error (see Configuration); no data update.
- RX_STOP returns to RX_IDLE in both cases.
- Clearing rx_en forces RX_IDLE on the next edge; a partial byte is discarded.
- A new byte arriving while rx_over=1 overwrites RX data; rx_over stays 1.

Simultaneous events:
- A STATUS write clearing rx_over in the same cycle a byte completes: set wins, rx_over=1.
- A BAUD write mid-frame affects only the next frame.

Reset (asynchronous, any time, including mid-frame):
- All FSMs return to IDLE; counters, CTRL, STATUS and RX data go to 0.
- BAUD goes to `BAUD_DIV_RST`; `tx_pin` goes to 1 immediately.

## Timing
- Register writes take effect at the `clk` edge with `we_i`=1. Reads are zero-latency, so the debug loader's set-address-then-read sequence sees the value in the following cycle.
- TX frame length is 10×BAUD cycles from the first TX_START cycle. tx_busy falls the cycle after the stop bit's last cycle, so back-to-back frames are possible with 1 idle cycle.
- RX latency: rx_over rises 2 (sync) + 1 (edge) + BAUD>>1 + 9×BAUD cycles (±1) after the line's falling edge.
- No bus stall; there is no ready signal.

## Configuration
- `UART_FRAME_ERR_EN` defined:
  - STATUS bit2 frame_err is set by a 0 stop-bit sample.
  - A STATUS write loads `data_i[2]`, clearing it on 0.
  - The bad byte is still discarded.
- Undefined: bit2 reads 0 and bad frames are dropped silently.

## Test plan
- **Reset defaults:** assert rst_n=0 mid-TX-frame → `tx_pin`=1 asynchronously, CTRL=0, STATUS=0, BAUD reads 434.
- **TX:** BAUD=8, CTRL=1, write TX=0xA5 → `tx_pin` shows 0,1,0,1,0,0,1,0,1,1 per 8-cycle bit. tx_busy is 1 for 80 cycles. A second TX write during busy is ignored.
- **RX:** BAUD=8, CTRL=2, drive 0x3C frame on `rx_pin` → STATUS bit1=1 and RX reads 0x0000_003C. Write STATUS=0 → bit1=0.
- **RX glitch:** a 2-cycle low pulse on `rx_pin` → no byte, rx_over stays 0.
- **Clear/set collision:** STATUS write 0 in the same cycle a byte completes → rx_over=1.
- **Frame error** (with `UART_FRAME_ERR_EN`): stop bit driven 0 → STATUS=0x4, RX unchanged. Without the macro: STATUS=0x0.
